// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, branch redirects and memory freezes.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch,
  input  logic              mem_busy,
  input  logic              ID_EX_MemRead,
  input  logic [REG_AW-1:0] ID_EX_Rd,
  input  logic [REG_AW-1:0] IF_ID_Rs1,
  input  logic [REG_AW-1:0] IF_ID_Rs2,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              pipe_hold,
  output logic              mux_to_pc,
  output logic              IF_Flush,
  output logic              ID_Flush,
  output logic [1:0]        ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    WAIT     = 2'b10,
    ILLEGAL  = 2'b11
  } stateT;

  stateT r_state;
  stateT w_nextState;
  logic  r_branchPending;
  logic  w_nextPending;
  logic  w_hazard;
  logic  w_redirect;

  assign w_hazard = ID_EX_MemRead && (ID_EX_Rd != '0) &&
                    ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
  assign w_redirect = branch || r_branchPending;
  assign ctrl_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= RUN;
      r_branchPending <= 1'b0;
    end else begin
      r_state         <= w_nextState;
      r_branchPending <= w_nextPending;
    end
  end

  // Priority: reset, then memory freeze, then redirect, then load-use stall.
  // A stall is only raised outside LU_STALL so each load-use pair gets one bubble.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    pipe_hold     = 1'b0;
    mux_to_pc     = 1'b0;
    IF_Flush      = 1'b0;
    ID_Flush      = 1'b0;
    w_nextState   = RUN;
    w_nextPending = r_branchPending;
    if (reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      IF_Flush      = 1'b1;
      ID_Flush      = 1'b1;
      w_nextPending = 1'b0;
    end else if (mem_busy) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      pipe_hold     = 1'b1;
      w_nextState   = WAIT;
      w_nextPending = r_branchPending || branch;
    end else if (w_redirect) begin
      mux_to_pc     = 1'b1;
      IF_Flush      = 1'b1;
      ID_Flush      = 1'b1;
      w_nextPending = 1'b0;
    end else if (w_hazard && (r_state == RUN || r_state == WAIT)) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ID_Flush      = 1'b1;
      w_nextState   = LU_STALL;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_flushCnt;

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (!pc_write)
        r_stallCnt <= r_stallCnt + 32'd1;
      if (mux_to_pc)
        r_flushCnt <= r_flushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, branch, mem_busy, ID_EX_MemRead;
  logic [4:0] ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2;
  logic       pc_write, if_id_write, pipe_hold, mux_to_pc, IF_Flush, ID_Flush;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Model: what happened last cycle, plus an outstanding branch captured during a freeze.
  bit frozenLast = 0;
  bit bubbleLast = 0;
  bit pendModel  = 0;
  int stallCount = 0;
  int flushCount = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5)) dut (
    .clk(clk), .reset(reset), .branch(branch), .mem_busy(mem_busy),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .pc_write(pc_write), .if_id_write(if_id_write), .pipe_hold(pipe_hold),
    .mux_to_pc(mux_to_pc), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush),
    .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Drive one cycle, compare against the model, clock it and advance the model.
  task automatic applyStimulus(input bit rst, input bit br, input bit mb, input bit mr,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bit loadUse, redirect, stall, flush;
    bit [5:0] expOut;
    logic [1:0] expState;
    reset = rst; branch = br; mem_busy = mb; ID_EX_MemRead = mr;
    ID_EX_Rd = rd; IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2;
    #1;
    loadUse  = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    redirect = br || pendModel;
    stall = 0; flush = 0;
    // Order of bits: pc_write, if_id_write, pipe_hold, mux_to_pc, IF_Flush, ID_Flush
    if (rst)                         expOut = 6'b000011;
    else if (mb)                     expOut = 6'b001000;
    else if (redirect) begin         expOut = 6'b110111; flush = 1; end
    else if (loadUse && !bubbleLast) begin expOut = 6'b000001; stall = 1; end
    else                             expOut = 6'b110000;
    expState = frozenLast ? 2'b10 : (bubbleLast ? 2'b01 : 2'b00);
    checkOutput("pc_write",    {31'd0, pc_write},    {31'd0, expOut[5]});
    checkOutput("if_id_write", {31'd0, if_id_write}, {31'd0, expOut[4]});
    checkOutput("pipe_hold",   {31'd0, pipe_hold},   {31'd0, expOut[3]});
    checkOutput("mux_to_pc",   {31'd0, mux_to_pc},   {31'd0, expOut[2]});
    checkOutput("IF_Flush",    {31'd0, IF_Flush},    {31'd0, expOut[1]});
    checkOutput("ID_Flush",    {31'd0, ID_Flush},    {31'd0, expOut[0]});
    checkOutput("ctrl_state",  {30'd0, ctrl_state},  {30'd0, expState});
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("stall_cnt", stall_cnt, stallCount);
    checkOutput("flush_cnt", flush_cnt, flushCount);
`endif
    @(posedge clk);
    if (rst) begin
      frozenLast = 0; bubbleLast = 0; pendModel = 0; stallCount = 0; flushCount = 0;
    end else begin
      if (mb || stall) stallCount++;
      if (flush) flushCount++;
      pendModel  = mb ? (pendModel || br) : 0;
      frozenLast = mb;
      bubbleLast = stall;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    reset = 1; branch = 0; mem_busy = 0; ID_EX_MemRead = 0;
    ID_EX_Rd = 0; IF_ID_Rs1 = 0; IF_ID_Rs2 = 0;
    @(posedge clk); #1;
    applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(2);

    // Rd = 0 never stalls
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    // Load-use held for two cycles gives exactly one bubble
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 5'd5, 5'd5, 5'd1);
    idle(1);
    // Branch together with a hazard: redirect wins
    applyStimulus(0, 1, 0, 1, 5'd7, 5'd2, 5'd7);
    idle(1);
    // Branch captured during a 3-cycle freeze, replayed once afterwards
    applyStimulus(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    idle(2);
    // Reset while in LU_STALL, then while in WAIT
    applyStimulus(0, 0, 0, 1, 5'd3, 5'd3, 5'd3);
    applyStimulus(1, 0, 0, 1, 5'd3, 5'd3, 5'd3);
    idle(1);
    applyStimulus(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 99) < 20),
                    ($urandom_range(0, 99) < 50),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port branch  input  1  taken branch resolved in EX this cycle.
REQ-005 SHALL have port mem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-006 SHALL have port ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-007 SHALL have port ID_EX_Rd  input  REG_AW  load destination register.
REQ-008 SHALL have ports IF_ID_Rs1 and IF_ID_Rs2  input  REG_AW each  source registers of the instruction in ID.
REQ-009 SHALL have port pc_write  output  1  PC update enable.
REQ-010 SHALL have port if_id_write  output  1  IF/ID register write enable.
REQ-011 SHALL have port pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB registers.
REQ-012 SHALL have port mux_to_pc  output  1  select branch target as next PC.
REQ-013 SHALL have ports IF_Flush and ID_Flush  output  1 each  zero IF/ID and ID/EX contents respectively.
REQ-014 SHALL have port ctrl_state  output  2  current FSM state encoding.

Function
REQ-015 SHALL implement FSM states RUN=2'b00, LU_STALL=2'b01, WAIT=2'b10; 2'b11 SHALL transition to RUN.
REQ-016 SHALL compute hazard = ID_EX_MemRead & (ID_EX_Rd != 0) & (ID_EX_Rd == IF_ID_Rs1 | ID_EX_Rd == IF_ID_Rs2).
REQ-017 SHALL drive all outputs combinationally from state, branch_pending and the current inputs; only state, branch_pending and counters are registered.
REQ-018 SHALL apply this priority in every state: mem_busy > redirect (branch | branch_pending) > hazard.
REQ-019 SHALL, when mem_busy=1: pc_write=0, if_id_write=0, pipe_hold=1, mux_to_pc=0, IF_Flush=0, ID_Flush=0; next state WAIT.
REQ-020 SHALL set branch_pending when branch=1 and mem_busy=1, and hold it until consumed.
REQ-021 SHALL, on redirect with mem_busy=0: mux_to_pc=1, IF_Flush=1, ID_Flush=1, pc_write=1, if_id_write=1, pipe_hold=0; clear branch_pending; next state RUN.
REQ-022 SHALL, in RUN with hazard=1, no redirect and mem_busy=0: pc_write=0, if_id_write=0, ID_Flush=1, IF_Flush=0, mux_to_pc=0; next state LU_STALL.
REQ-023 SHALL ignore hazard in LU_STALL (exactly one bubble per load-use pair) and return to RUN unless mem_busy or redirect dictate otherwise.
REQ-024 SHALL leave WAIT when mem_busy=0 on the same cycle, applying REQ-021/022 rules that cycle.
REQ-025 SHALL, with no event, output pc_write=1, if_id_write=1, all others 0.
REQ-026 SHALL discard a load-use stall when a redirect occurs in the same cycle (ID instruction is wrong-path).

Reset
REQ-027 SHALL, while reset=1 at a rising edge, set state=RUN, branch_pending=0, counters=0.
REQ-028 SHALL force outputs during reset cycle: pc_write=0, if_id_write=0, pipe_hold=0, mux_to_pc=0, IF_Flush=1, ID_Flush=1.
REQ-029 SHALL drop any pending redirect or stall when reset asserts mid-operation.

Configuration
REQ-030 SHALL, with macro HAZARD_PERF_CNT_EN defined, add outputs stall_cnt[31:0] (cycles with pc_write=0 outside reset) and flush_cnt[31:0] (redirect cycles), each wrapping 0xFFFFFFFF->0.
REQ-031 SHALL, without HAZARD_PERF_CNT_EN, omit both ports and counter logic; all other behaviour identical.

Verification
REQ-032 Load-use: ID_EX_MemRead=1, Rd=5, Rs1=5 for 2 cycles -> exactly 1 cycle pc_write=0, ID_Flush=1; ctrl_state RUN->LU_STALL->RUN.
REQ-033 Rd=0 with MemRead=1, Rs1=0 -> no stall, pc_write=1 every cycle.
REQ-034 branch=1 and hazard=1 same cycle -> mux_to_pc=1, IF_Flush=1, ID_Flush=1, pc_write=1; no LU_STALL entry.
REQ-035 branch=1 with mem_busy=1 for 3 cycles, branch deasserted -> pipe_hold=1 for 3 cycles, then one cycle mux_to_pc=1, flushes=1; branch_pending=0 after.
REQ-036 reset asserted in LU_STALL and WAIT -> next cycle ctrl_state=RUN, branch_pending=0, counters 0.
REQ-037 HAZARD_PERF_CNT_EN: preload-equivalent run of 4 stalls, 2 redirects -> stall_cnt=4, flush_cnt=2; counter at 0xFFFFFFFF wraps to 0.
